// File: rtl/move_sequencer.sv
// Player move sequencer: turns direction keys into single, maze-checked moves
// on a (MAX_COORD+1)-square grid, with timeout, game-end halt and restart.
module move_sequencer #(
  parameter logic [4:0] START_X   = 5'd1,
  parameter logic [4:0] START_Y   = 5'd0,
  parameter logic [4:0] MAX_COORD = 5'd19,
  parameter logic [7:0] TIMEOUT   = 8'd15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ext_reset,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       game_won,
  input  logic       game_over,
  input  logic       legal_done,
  input  logic       legal_ok,
  output logic       legal_req,
  output logic [4:0] chk_x,
  output logic [4:0] chk_y,
  output logic [4:0] pos_x,
  output logic [4:0] pos_y,
  output logic [4:0] prev_x,
  output logic [4:0] prev_y,
  output logic [7:0] move_count,
  output logic       move_done,
  output logic       move_rej,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_CHECK, S_COMMIT, S_REJECT, S_RELEASE, S_HALT
  } state_t;

  typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_t;

  state_t     state, state_next;
  dir_t       dir, key_dir;
  logic [7:0] tmo_cnt;
  logic [4:0] cand_x, cand_y;
  logic       cand_oob;
  logic       any_key, game_end;

  assign any_key  = key_left | key_right | key_up | key_down;
  assign game_end = game_won | game_over;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    key_dir = D_DOWN;
    if (key_left)       key_dir = D_LEFT;
    else if (key_right) key_dir = D_RIGHT;
    else if (key_up)    key_dir = D_UP;
  end

  // Row 0 is the top of the grid: up decrements y, down increments it.
  always_comb begin
    cand_x   = pos_x;
    cand_y   = pos_y;
    cand_oob = 1'b0;
    case (dir)
      D_LEFT: begin
        cand_oob = (pos_x == 5'd0);
        cand_x   = pos_x - 5'd1;
      end
      D_RIGHT: begin
        cand_oob = (pos_x >= MAX_COORD);
        cand_x   = pos_x + 5'd1;
      end
      D_UP: begin
        cand_oob = (pos_y == 5'd0);
        cand_y   = pos_y - 5'd1;
      end
      D_DOWN: begin
        cand_oob = (pos_y >= MAX_COORD);
        cand_y   = pos_y + 5'd1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Restart beats everything; a game flag beats everything except a commit in flight.
  always_comb begin
    state_next = state;
    if (ext_reset) begin
      state_next = S_IDLE;
    end else if (game_end && state != S_COMMIT) begin
      state_next = S_HALT;
    end else begin
      case (state)
        S_IDLE:    if (any_key) state_next = S_CALC;
        S_CALC:    state_next = cand_oob ? S_REJECT : S_CHECK;
        S_CHECK: begin
          if (legal_done)                       state_next = legal_ok ? S_COMMIT : S_REJECT;
          else if (tmo_cnt >= TIMEOUT - 8'd1)   state_next = S_REJECT;
        end
        S_COMMIT:  state_next = game_end ? S_HALT : S_RELEASE;
        S_REJECT:  state_next = S_RELEASE;
        S_RELEASE: if (!any_key) state_next = S_IDLE;
        S_HALT:    state_next = S_HALT;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    legal_req = (state == S_CHECK);
    move_done = (state == S_COMMIT);
    move_rej  = (state == S_REJECT);
    busy      = (state != S_IDLE) && (state != S_HALT);
  end

  // NOTE: only control/datapath registers are reset here; there is no memory array to clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dir        <= D_LEFT;
      tmo_cnt    <= '0;
      chk_x      <= START_X;
      chk_y      <= START_Y;
      pos_x      <= START_X;
      pos_y      <= START_Y;
      prev_x     <= START_X;
      prev_y     <= START_Y;
      move_count <= '0;
    end else if (ext_reset) begin
      dir        <= D_LEFT;
      tmo_cnt    <= '0;
      chk_x      <= START_X;
      chk_y      <= START_Y;
      pos_x      <= START_X;
      pos_y      <= START_Y;
      prev_x     <= START_X;
      prev_y     <= START_Y;
      move_count <= '0;
    end else begin
      if (state == S_IDLE) dir <= key_dir;
      if (state == S_CALC) tmo_cnt <= '0;
      if (state == S_CALC && state_next == S_CHECK) begin
        chk_x <= cand_x;
        chk_y <= cand_y;
      end
      if (state == S_CHECK && tmo_cnt != 8'hff) tmo_cnt <= tmo_cnt + 8'd1;
      if (state == S_COMMIT) begin
        prev_x <= pos_x;
        prev_y <= pos_y;
        pos_x  <= chk_x;
        pos_y  <= chk_y;
        if (move_count != 8'hff) move_count <= move_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed scenarios plus random moves
// compared against a grid-walk reference model.
module tb_move_sequencer;

  localparam int MAXC = 19;
  localparam int TMO  = 15;

  logic       clock = 1'b0;
  logic       resetn, ext_reset;
  logic       key_left, key_right, key_up, key_down;
  logic       game_won, game_over, legal_done, legal_ok;
  logic       legal_req, move_done, move_rej, busy;
  logic [4:0] chk_x, chk_y, pos_x, pos_y, prev_x, prev_y;
  logic [7:0] move_count;

  int total  = 0;
  int passed = 0;

  // Reference model: player position, previous position, accepted-move count.
  int m_x, m_y, m_px, m_py, m_cnt;

  move_sequencer dut (
    .clock(clock), .resetn(resetn), .ext_reset(ext_reset),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .game_won(game_won), .game_over(game_over),
    .legal_done(legal_done), .legal_ok(legal_ok),
    .legal_req(legal_req), .chk_x(chk_x), .chk_y(chk_y),
    .pos_x(pos_x), .pos_y(pos_y), .prev_x(prev_x), .prev_y(prev_y),
    .move_count(move_count), .move_done(move_done), .move_rej(move_rej), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic model_reset();
    m_x = 1; m_y = 0; m_px = 1; m_py = 0; m_cnt = 0;
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_left, key_right, key_up, key_down} = k;
  endtask

  task automatic do_ext_reset();
    @(negedge clock);
    set_keys(4'b0000);
    legal_done = 1'b0;
    ext_reset  = 1'b1;
    @(negedge clock);
    ext_reset = 1'b0;
    model_reset();
  endtask

  // One key press held for `hold` cycles. latency = CHECK cycle (1-based) on
  // which legal_done is given; 0 or >TMO means the lookup never answers.
  task automatic run_move(input string name, input logic [3:0] keys,
                          input int latency, input bit ok, input int hold);
    int ex, ey, exp_req, req, dones, rejs, chk_bad, waited;
    bit oob, accept;
    ex = m_x; ey = m_y;
    if (keys[3])      ex = m_x - 1;
    else if (keys[2]) ex = m_x + 1;
    else if (keys[1]) ey = m_y - 1;
    else              ey = m_y + 1;
    oob     = (ex < 0) || (ex > MAXC) || (ey < 0) || (ey > MAXC);
    accept  = !oob && latency >= 1 && latency <= TMO && ok;
    exp_req = oob ? 0 : ((latency >= 1 && latency <= TMO) ? latency : TMO);

    req = 0; dones = 0; rejs = 0; chk_bad = 0;
    @(negedge clock);
    set_keys(keys);
    legal_done = 1'b0;
    for (int c = 0; c < hold; c++) begin
      @(negedge clock);
      dones += int'(move_done);
      rejs  += int'(move_rej);
      if (legal_req === 1'b1) begin
        req++;
        if (chk_x !== 5'(ex) || chk_y !== 5'(ey)) chk_bad++;
        legal_done = (req == latency);
        legal_ok   = ok;
      end else begin
        // Stray lookup strobes outside CHECK must have no effect.
        legal_done = 1'($urandom_range(0, 1));
        legal_ok   = 1'($urandom_range(0, 1));
      end
    end
    set_keys(4'b0000);
    legal_done = 1'b0;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (busy !== 1'b0 && waited < 8);

    if (accept) begin
      m_px = m_x; m_py = m_y; m_x = ex; m_y = ey;
      if (m_cnt < 255) m_cnt++;
    end

    total++;
    if (busy !== 1'b0) $display("FAIL %s idle_after_release: busy=%b, expected 0", name, busy);
    else passed++;
    total++;
    if (req !== exp_req) $display("FAIL %s legal_req_cycles: got %0d, expected %0d", name, req, exp_req);
    else passed++;
    total++;
    if (dones !== int'(accept) || rejs !== int'(!accept))
      $display("FAIL %s pulses: done=%0d rej=%0d, expected done=%0d rej=%0d",
               name, dones, rejs, int'(accept), int'(!accept));
    else passed++;
    total++;
    if (chk_bad !== 0) $display("FAIL %s chk_stable: %0d bad cycles, expected 0 (cand %0d,%0d)", name, chk_bad, ex, ey);
    else passed++;
    total++;
    if (pos_x !== 5'(m_x) || pos_y !== 5'(m_y))
      $display("FAIL %s pos: got (%0d,%0d), expected (%0d,%0d)", name, pos_x, pos_y, m_x, m_y);
    else passed++;
    total++;
    if (prev_x !== 5'(m_px) || prev_y !== 5'(m_py))
      $display("FAIL %s prev: got (%0d,%0d), expected (%0d,%0d)", name, prev_x, prev_y, m_px, m_py);
    else passed++;
    total++;
    if (move_count !== 8'(m_cnt)) $display("FAIL %s move_count: got %0d, expected %0d", name, move_count, m_cnt);
    else passed++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; ext_reset = 1'b0; set_keys(4'b0000);
    game_won = 1'b0; game_over = 1'b0; legal_done = 1'b0; legal_ok = 1'b0;
    model_reset();
    #23;
    total++;
    if ({pos_x, pos_y, prev_x, prev_y, chk_x, chk_y} !== {5'd1, 5'd0, 5'd1, 5'd0, 5'd1, 5'd0})
      $display("FAIL reset_coords: pos=(%0d,%0d) prev=(%0d,%0d) chk=(%0d,%0d), expected all (1,0)",
               pos_x, pos_y, prev_x, prev_y, chk_x, chk_y);
    else passed++;
    total++;
    if ({move_count, legal_req, move_done, move_rej, busy} !== 12'd0)
      $display("FAIL reset_flags: count=%0d req=%b done=%b rej=%b busy=%b, expected all 0",
               move_count, legal_req, move_done, move_rej, busy);
    else passed++;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    run_move("basic_right", 4'b0100, 2, 1'b1, 14);
    total++;
    if ({pos_x, pos_y, prev_x, prev_y, move_count} !== {5'd2, 5'd0, 5'd1, 5'd0, 8'd1})
      $display("FAIL basic_final: pos=(%0d,%0d) prev=(%0d,%0d) count=%0d, expected (2,0) (1,0) 1",
               pos_x, pos_y, prev_x, prev_y, move_count);
    else passed++;
  endtask

  task automatic test_boundary();
    do_ext_reset();
    run_move("walk_left", 4'b1000, 1, 1'b1, 6);
    for (int i = 0; i < 5; i++) run_move("walk_down", 4'b0001, 1, 1'b1, 6);
    run_move("edge_left", 4'b1000, 1, 1'b1, 8);
    for (int i = 0; i < MAXC; i++) run_move("walk_right", 4'b0100, 1, 1'b1, 6);
    run_move("edge_right", 4'b0100, 1, 1'b1, 8);
    total++;
    if (pos_x !== 5'd19 || pos_y !== 5'd5)
      $display("FAIL edge_final: pos=(%0d,%0d), expected (19,5)", pos_x, pos_y);
    else passed++;
  endtask

  task automatic test_timeout();
    run_move("timeout_down", 4'b0001, 0, 1'b1, 20);
  endtask

  task automatic test_priority();
    run_move("left_over_up", 4'b1010, 3, 1'b1, 10);
    run_move("right_over_down", 4'b0101, 15, 1'b1, 20);
    run_move("up_over_down_nok", 4'b0011, 4, 1'b0, 10);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++)
      run_move("random", 4'($urandom_range(1, 15)), int'($urandom_range(0, 17)),
               1'($urandom_range(0, 3) != 0), 20);
  endtask

  task automatic test_saturate();
    do_ext_reset();
    for (int i = 0; i < 257; i++)
      run_move("saturate", (i % 2 == 0) ? 4'b0100 : 4'b1000, 1, 1'b1, 5);
    total++;
    if (move_count !== 8'd255) $display("FAIL saturate_final: count=%0d, expected 255", move_count);
    else passed++;
  endtask

  task automatic test_halt();
    int waited, pulses, busy_seen;
    do_ext_reset();
    run_move("pre_halt", 4'b0100, 1, 1'b1, 6);
    @(negedge clock);
    set_keys(4'b0001);
    waited = 0;
    while (legal_req !== 1'b1 && waited < 6) begin
      @(negedge clock);
      waited++;
    end
    total++;
    if (legal_req !== 1'b1) $display("FAIL halt_reach_check: legal_req=%b, expected 1", legal_req);
    else passed++;
    game_over  = 1'b1;
    legal_done = 1'b1;
    legal_ok   = 1'b1;
    @(negedge clock);
    total++;
    if ({legal_req, move_done, move_rej, busy} !== 4'b0000)
      $display("FAIL halt_entry: req=%b done=%b rej=%b busy=%b, expected all 0",
               legal_req, move_done, move_rej, busy);
    else passed++;
    game_over = 1'b0;
    pulses = 0; busy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      set_keys(4'($urandom_range(1, 15)));
      legal_done = 1'b1;
      @(negedge clock);
      pulses    += int'(move_done) + int'(move_rej) + int'(legal_req);
      busy_seen += int'(busy);
    end
    total++;
    if (pulses !== 0 || busy_seen !== 0)
      $display("FAIL halt_ignores_keys: activity=%0d busy_cycles=%0d, expected 0 and 0", pulses, busy_seen);
    else passed++;
    total++;
    if ({pos_x, pos_y, move_count} !== {5'd2, 5'd0, 8'd1})
      $display("FAIL halt_frozen: pos=(%0d,%0d) count=%0d, expected (2,0) 1", pos_x, pos_y, move_count);
    else passed++;
    do_ext_reset();
    total++;
    if ({pos_x, pos_y, prev_x, prev_y, move_count, busy} !== {5'd1, 5'd0, 5'd1, 5'd0, 8'd0, 1'b0})
      $display("FAIL ext_reset_from_halt: pos=(%0d,%0d) prev=(%0d,%0d) count=%0d busy=%b, expected (1,0) (1,0) 0 0",
               pos_x, pos_y, prev_x, prev_y, move_count, busy);
    else passed++;
    run_move("after_restart", 4'b0001, 2, 1'b1, 8);

    // A game flag rising during COMMIT must not cancel the commit.
    do_ext_reset();
    @(negedge clock);
    set_keys(4'b0100);
    waited = 0;
    while (move_done !== 1'b1 && waited < 8) begin
      @(negedge clock);
      waited++;
      legal_done = legal_req;
      legal_ok   = 1'b1;
    end
    total++;
    if (move_done !== 1'b1) $display("FAIL commit_flag_reach: move_done=%b, expected 1", move_done);
    else passed++;
    game_won = 1'b1;
    @(negedge clock);
    total++;
    if ({pos_x, pos_y, move_count, busy, move_done} !== {5'd2, 5'd0, 8'd1, 1'b0, 1'b0})
      $display("FAIL commit_then_halt: pos=(%0d,%0d) count=%0d busy=%b done=%b, expected (2,0) 1 0 0",
               pos_x, pos_y, move_count, busy, move_done);
    else passed++;
    game_won = 1'b0;
    do_ext_reset();
  endtask

  task automatic test_async_reset();
    int waited;
    run_move("pre_async", 4'b0100, 1, 1'b1, 6);
    @(negedge clock);
    set_keys(4'b0001);
    waited = 0;
    while (legal_req !== 1'b1 && waited < 6) begin
      @(negedge clock);
      waited++;
    end
    #1 resetn = 1'b0;
    #1;
    total++;
    if ({legal_req, busy, move_done, move_rej, move_count, pos_x, pos_y, chk_x, chk_y}
        !== {4'b0000, 8'd0, 5'd1, 5'd0, 5'd1, 5'd0})
      $display("FAIL async_reset: req=%b busy=%b count=%0d pos=(%0d,%0d) chk=(%0d,%0d), expected 0 0 0 (1,0) (1,0)",
               legal_req, busy, move_count, pos_x, pos_y, chk_x, chk_y);
    else passed++;
    @(negedge clock);
    set_keys(4'b0000);
    resetn = 1'b1;
    model_reset();
    run_move("after_async", 4'b0001, 1, 1'b1, 6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_timeout();
    test_priority();
    test_random();
    test_saturate();
    test_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
